// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory port between the CPU (port 0)
// and the loader/DMA engine (port 1). Grants are registered; bursts are bounded.
//
// state | meaning
// IDLE  | nobody owns the port
// OWN0  | CPU owns the port
// OWN1  | loader owns the port
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_adr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          owner_busy
);

    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] beat_cnt, beat_cnt_nxt;
    logic          last_owner, last_owner_nxt;
    logic          beat0, beat1, cnt_last;

    assign gnt0       = (state == OWN0);
    assign gnt1       = (state == OWN1);
    assign owner_busy = gnt0 | gnt1;
    assign beat0      = gnt0 & req0;
    assign beat1      = gnt1 & req1;
    assign cnt_last   = (beat_cnt == CW'(MAX_BURST - 1));

    // Port mux is gated by the beat so a dead grant cycle never writes.
    always_comb begin
        mem_adr   = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (beat0) begin
            mem_adr   = adr0;
            mem_wdata = wdata0;
            mem_we    = we0;
        end else if (beat1) begin
            mem_adr   = adr1;
            mem_wdata = wdata1;
            mem_we    = we1;
        end
    end

    assign rdata = mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_cnt_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!req0)
                    state_nxt = req1 ? OWN1 : IDLE;
                else if (cnt_last && req1)
                    state_nxt = OWN1;
            end
            OWN1: begin
                if (!req1)
                    state_nxt = req0 ? OWN0 : IDLE;
                else if (cnt_last && req0)
                    state_nxt = OWN0;
            end
            default: state_nxt = IDLE;
        endcase

        if (state == OWN0 && state_nxt != OWN0)
            last_owner_nxt = 1'b0;
        else if (state == OWN1 && state_nxt != OWN1)
            last_owner_nxt = 1'b1;
    end

    // Count wraps at the burst limit so an uncontested owner streams without a gap.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        if (state_nxt != state)
            beat_cnt_nxt = '0;
        else if (beat0 || beat1)
            beat_cnt_nxt = cnt_last ? '0 : beat_cnt + CW'(1);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written corner
// sequences and a randomized run against an ownership-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic       clk, reset;
    logic       req0, we0, req1, we1;
    logic [7:0] adr0, wdata0, adr1, wdata1;
    logic       gnt0, gnt1, mem_we, owner_busy;
    logic [7:0] mem_rdata, rdata, mem_adr, mem_wdata;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    assign mem_rdata = mem[mem_adr];

    mem_port_arbiter #(.AW(8), .DW(8), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wdata0(wdata0), .gnt0(gnt0),
        .req1(req1), .we1(we1), .adr1(adr1), .wdata1(wdata1), .gnt1(gnt1),
        .mem_rdata(mem_rdata), .rdata(rdata), .mem_adr(mem_adr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .owner_busy(owner_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic       g0, g1, mwe;
        logic [7:0] madr, mwd;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Memory write lands after the mid-cycle checks, standing in for the clock edge.
    task automatic next_cycle();
        if (mem_we === 1'b1) mem[mem_adr] = mem_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; we0 = 0; adr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; adr1 = 0; wdata1 = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk);
        next_cycle();
        reset = 0;
    endtask

    // Reference model: who owns the port, who owned it last, beats in current tenure.
    int m_owner, m_last, m_run;

    task automatic model_check_and_step();
        logic       beat, rx, ry;
        logic [7:0] e_adr, e_wd;
        logic       e_we;
        beat  = (m_owner == 0 && req0) || (m_owner == 1 && req1);
        e_adr = !beat ? 8'h00 : (m_owner == 0 ? adr0 : adr1);
        e_wd  = !beat ? 8'h00 : (m_owner == 0 ? wdata0 : wdata1);
        e_we  = !beat ? 1'b0 : (m_owner == 0 ? we0 : we1);
        if (reset) begin
            e_adr = 0; e_wd = 0; e_we = 0;
        end
        chk("rnd_gnt0", {7'd0, gnt0}, {7'd0, (!reset && m_owner == 0)});
        chk("rnd_gnt1", {7'd0, gnt1}, {7'd0, (!reset && m_owner == 1)});
        chk("rnd_mem_we", {7'd0, mem_we}, {7'd0, e_we});
        chk("rnd_mem_adr", mem_adr, e_adr);
        chk("rnd_mem_wdata", mem_wdata, e_wd);
        chk("rnd_rdata", rdata, mem[e_adr]);
        chk("rnd_busy", {7'd0, owner_busy}, {7'd0, (!reset && m_owner >= 0)});
        if (reset) begin
            m_owner = -1; m_last = 1; m_run = 0;
        end else if (m_owner < 0) begin
            if (req0 && req1) m_owner = 1 - m_last;
            else if (req0)    m_owner = 0;
            else if (req1)    m_owner = 1;
            m_run = 0;
        end else begin
            rx = (m_owner == 0) ? req0 : req1;
            ry = (m_owner == 0) ? req1 : req0;
            if (!rx) begin
                m_last  = m_owner;
                m_owner = ry ? 1 - m_owner : -1;
                m_run   = 0;
            end else begin
                m_run++;
                if (ry && (m_run % MAXB) == 0) begin
                    m_last  = m_owner;
                    m_owner = 1 - m_owner;
                    m_run   = 0;
                end
            end
        end
    endtask

    initial begin
        logic [7:0] fetch_exp [4];
        fetch_exp[0] = 8'h20; fetch_exp[1] = 8'h01; fetch_exp[2] = 8'h02; fetch_exp[3] = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 4; i++) mem[i] = fetch_exp[i];

        //            r0 w0 a0     d0     r1 w1 a1     d1     g0 g1 we madr   mwd
        tbl[0]  = '{1, 0, 8'h10, 8'h00, 1, 1, 8'h40, 8'hA5, 0, 0, 0, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 8'h10, 8'h00, 1, 1, 8'h40, 8'hA5, 1, 0, 0, 8'h10, 8'h00};
        tbl[2]  = '{1, 0, 8'h11, 8'h00, 1, 1, 8'h40, 8'hA5, 1, 0, 0, 8'h11, 8'h00};
        tbl[3]  = '{1, 0, 8'h12, 8'h00, 1, 1, 8'h40, 8'hA5, 1, 0, 0, 8'h12, 8'h00};
        tbl[4]  = '{1, 0, 8'h13, 8'h00, 1, 1, 8'h40, 8'hA5, 1, 0, 0, 8'h13, 8'h00};
        tbl[5]  = '{1, 0, 8'h14, 8'h00, 1, 1, 8'h40, 8'hA5, 0, 1, 1, 8'h40, 8'hA5};
        tbl[6]  = '{1, 0, 8'h14, 8'h00, 0, 1, 8'h40, 8'hA5, 0, 1, 0, 8'h00, 8'h00};
        tbl[7]  = '{1, 1, 8'h14, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h14, 8'h77};
        tbl[8]  = '{0, 1, 8'h14, 8'h77, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00};
        tbl[9]  = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h40, 8'hA5, 0, 0, 0, 8'h00, 8'h00};
        tbl[10] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h40, 8'hA5, 0, 1, 1, 8'h40, 8'hA5};
        tbl[11] = '{1, 0, 8'h20, 8'h00, 0, 1, 8'h40, 8'hA5, 0, 1, 0, 8'h00, 8'h00};
        tbl[12] = '{0, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 8'h00};
        tbl[13] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h5A, 0, 0, 0, 8'h00, 8'h00};
        tbl[14] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h5A, 0, 1, 1, 8'h41, 8'h5A};
        tbl[15] = '{0, 0, 8'h00, 8'h00, 0, 1, 8'h41, 8'h5A, 0, 1, 0, 8'h00, 8'h00};
        tbl[16] = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00};

        idle_inputs();
        reset = 1;
        @(posedge clk);
        #1;

        // Reset held with the CPU already requesting, then a 4-byte fetch.
        req0 = 1; adr0 = 8'h00;
        @(negedge clk);
        chk("rst_gnt0", {7'd0, gnt0}, 8'd0);
        chk("rst_gnt1", {7'd0, gnt1}, 8'd0);
        chk("rst_mem_we", {7'd0, mem_we}, 8'd0);
        next_cycle();
        reset = 0;
        @(negedge clk);
        chk("idle_gnt0", {7'd0, gnt0}, 8'd0);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            adr0 = 8'(i);
            @(negedge clk);
            chk("fetch_gnt0", {7'd0, gnt0}, 8'd1);
            chk("fetch_mem_adr", mem_adr, 8'(i));
            chk("fetch_mem_we", {7'd0, mem_we}, 8'd0);
            chk("fetch_rdata", rdata, fetch_exp[i]);
            next_cycle();
        end

        // Contention, forced rotation, handover and dead cycles from the table.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; adr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; adr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            @(negedge clk);
            chk($sformatf("tbl%0d_gnt0", i), {7'd0, gnt0}, {7'd0, tbl[i].g0});
            chk($sformatf("tbl%0d_gnt1", i), {7'd0, gnt1}, {7'd0, tbl[i].g1});
            chk($sformatf("tbl%0d_mem_we", i), {7'd0, mem_we}, {7'd0, tbl[i].mwe});
            chk($sformatf("tbl%0d_mem_adr", i), mem_adr, tbl[i].madr);
            chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].mwd);
            chk($sformatf("tbl%0d_busy", i), {7'd0, owner_busy}, {7'd0, tbl[i].g0 | tbl[i].g1});
            next_cycle();
        end
        chk("mem_written_40", mem[8'h40], 8'hA5);

        // Loader alone streams 10 beats with no dead cycle at the burst wrap.
        do_reset();
        req1 = 1; we1 = 1; adr1 = 8'h80; wdata1 = 8'h00;
        @(negedge clk);
        chk("ldr_pre_gnt1", {7'd0, gnt1}, 8'd0);
        chk("ldr_pre_mem_we", {7'd0, mem_we}, 8'd0);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            adr1 = 8'(8'h80 + i); wdata1 = 8'(i);
            @(negedge clk);
            chk("ldr_gnt1", {7'd0, gnt1}, 8'd1);
            chk("ldr_mem_we", {7'd0, mem_we}, 8'd1);
            chk("ldr_mem_adr", mem_adr, 8'(8'h80 + i));
            next_cycle();
        end

        // Reset lands during the 3rd beat of a CPU write burst.
        do_reset();
        req0 = 1; we0 = 1; adr0 = 8'h30; wdata0 = 8'h11;
        req1 = 1; we1 = 0; adr1 = 8'h50;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            adr0 = 8'(8'h30 + i);
            if (i == 2) begin
                #2 reset = 1;
            end
            @(negedge clk);
            if (i < 2) begin
                chk("mid_gnt0", {7'd0, gnt0}, 8'd1);
                chk("mid_mem_we", {7'd0, mem_we}, 8'd1);
            end else begin
                chk("midrst_gnt0", {7'd0, gnt0}, 8'd0);
                chk("midrst_gnt1", {7'd0, gnt1}, 8'd0);
                chk("midrst_mem_we", {7'd0, mem_we}, 8'd0);
            end
            next_cycle();
        end
        reset = 0;
        @(negedge clk);
        chk("post_rst_idle", {7'd0, owner_busy}, 8'd0);
        next_cycle();
        for (int i = 0; i < MAXB; i++) begin
            @(negedge clk);
            chk("post_rst_cpu_beat", {7'd0, gnt0}, 8'd1);
            next_cycle();
        end
        @(negedge clk);
        chk("post_rst_rotate", {7'd0, gnt1}, 8'd1);
        next_cycle();

        // Randomized traffic, including occasional resets, against the model.
        do_reset();
        m_owner = -1; m_last = 1; m_run = 0;
        for (int c = 0; c < 2000; c++) begin
            reset  = ($urandom_range(0, 99) == 0);
            req0   = ($urandom_range(0, 3) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            we0    = 1'($urandom);
            we1    = 1'($urandom);
            adr0   = 8'($urandom);
            adr1   = 8'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            @(negedge clk);
            model_check_and_step();
            next_cycle();
        end
        reset = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
